resp_sig_collector: RTL and testbench

- Hardware response-side counterpart to the LCG stimulus driver used around the flattened `top` DUT.
- Consumes the DUT's flattened output vector one beat per cycle and discards a programmable warm-up window.
- Compacts the remaining beats into a 32-bit MISR signature and compares it against an expected value after a programmed beat count.
- Lets long fuzz runs be checked by a single pass/fail result instead of per-cycle text dumps.

---
 rtl/resp_sig_pkg.sv | 28 ++
 rtl/misr32.sv | 45 ++++
 rtl/resp_sig_collector.sv | 140 ++++++++++++++
 tb/tb_resp_sig_collector.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/resp_sig_pkg.sv
// Shared types and helpers for the response-signature collector: FSM states,
// default MISR constants and the word XOR-fold used to compact a response beat.
package resp_sig_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WARMUP  = 2'd1,
    COLLECT = 2'd2,
    DONE    = 2'd3
  } state_e;

  localparam logic [31:0] SEED_DEFAULT = 32'hFFFF_FFFF;
  localparam logic [31:0] POLY_DEFAULT = 32'h04C1_1DB7;

  // Widest response vector fold32 accepts; callers zero-extend into this width.
  localparam int unsigned FOLD_MAX_W = 512;
  localparam int unsigned FOLD_WORDS = FOLD_MAX_W / 32;

  function automatic logic [31:0] fold32(input logic [FOLD_MAX_W-1:0] data);
    logic [31:0] acc;
    acc = '0;
    for (int unsigned w = 0; w < FOLD_WORDS; w++) begin
      acc = acc ^ data[w*32 +: 32];
    end
    return acc;
  endfunction

endpackage

// File: rtl/misr32.sv
// 32-bit multiple-input signature register: shift with polynomial feedback and
// XOR in one folded data word per enabled cycle; load_seed has priority.
module misr32 #(
  parameter logic [31:0] SEED = 32'hFFFF_FFFF,
  parameter logic [31:0] POLY = 32'h04C1_1DB7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_seed_i,
  input  logic        enable_i,
  input  logic [31:0] data_in_i,
  output logic [31:0] sig_o,
  output logic [31:0] sig_next_o
);

  logic [31:0] sig_q;
  logic [31:0] sig_d;
  logic [31:0] step;

  // NOTE: every signal written in always_comb gets a default first so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    step  = {sig_q[30:0], 1'b0} ^ (sig_q[31] ? POLY : 32'h0) ^ data_in_i;
    sig_d = sig_q;
    if (load_seed_i) begin
      sig_d = SEED;
    end else if (enable_i) begin
      sig_d = step;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sig_q <= SEED;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig_o      = sig_q;
  assign sig_next_o = step;

endmodule

// File: rtl/resp_sig_collector.sv
// Response-side signature collector: discards SKIP warm-up beats, compacts the
// next num_beats valid beats into a MISR and compares against a golden value.
module resp_sig_collector
  import resp_sig_pkg::*;
#(
  parameter int          DATA_W = 159,
  parameter int          SKIP   = 2,
  parameter logic [31:0] SEED   = SEED_DEFAULT,
  parameter logic [31:0] POLY   = POLY_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [31:0]       num_beats,
  input  logic [31:0]       expected_sig,
  input  logic              resp_valid,
  input  logic [DATA_W-1:0] resp_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [31:0]       signature,
  output logic [31:0]       beat_count
);

  localparam logic [31:0] SKIP_LAST = 32'((SKIP > 0) ? SKIP - 1 : 0);
  localparam state_e      ARM_STATE = (SKIP > 0) ? WARMUP : COLLECT;

  state_e      state_q;
  logic [31:0] num_beats_q;
  logic [31:0] expected_q;
  logic [31:0] beat_count_q;
  logic [31:0] skip_cnt_q;
  logic        busy_q;
  logic        done_q;
  logic        pass_q;

  logic                  start_ok;
  logic                  misr_en;
  logic                  last_beat;
  logic [FOLD_MAX_W-1:0] data_ext;
  logic [31:0]           fold_word;
  logic [31:0]           sig_now;
  logic [31:0]           sig_next;

  // start is only honoured while idle or parked in DONE.
  assign start_ok  = start && ((state_q == IDLE) || (state_q == DONE));
  assign misr_en   = (state_q == COLLECT) && resp_valid;
  assign last_beat = (beat_count_q + 32'd1) == num_beats_q;

  always_comb begin
    data_ext               = '0;
    data_ext[DATA_W-1:0]   = resp_data;
    fold_word              = fold32(data_ext);
  end

  misr32 #(
    .SEED (SEED),
    .POLY (POLY)
  ) u_misr (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_seed_i (start_ok),
    .enable_i    (misr_en),
    .data_in_i   (fold_word),
    .sig_o       (sig_now),
    .sig_next_o  (sig_next)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      num_beats_q  <= '0;
      expected_q   <= '0;
      beat_count_q <= '0;
      skip_cnt_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            num_beats_q  <= num_beats;
            expected_q   <= expected_sig;
            beat_count_q <= '0;
            skip_cnt_q   <= '0;
            if (num_beats == 32'd0) begin
              // Empty run: the signature stays at SEED, so judge it directly.
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (SEED == expected_sig);
            end else begin
              state_q <= ARM_STATE;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
              pass_q  <= 1'b0;
            end
          end
        end

        WARMUP: begin
          if (resp_valid) begin
            skip_cnt_q <= skip_cnt_q + 32'd1;
            if (skip_cnt_q == SKIP_LAST) begin
              state_q <= COLLECT;
            end
          end
        end

        COLLECT: begin
          if (resp_valid) begin
            beat_count_q <= beat_count_q + 32'd1;
            if (last_beat) begin
              // Compare the value the MISR is taking on this same edge.
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (sig_next == expected_q);
            end
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          pass_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign signature  = sig_now;
  assign beat_count = beat_count_q;

endmodule

// File: tb/tb_resp_sig_collector.sv
// Directed bench for resp_sig_collector: table of single-pattern runs with
// hand-computed signatures, plus sequences for reset, stalls and re-arm.
module tb_resp_sig_collector;

  localparam int          DATA_W = 159;
  localparam logic [31:0] POLY   = 32'h04C1_1DB7;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [31:0]       num_beats;
  logic [31:0]       expected_sig;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_data;
  logic              busy;
  logic              done;
  logic              pass;
  logic [31:0]       signature;
  logic [31:0]       beat_count;

  int errors = 0;
  int checks = 0;

  resp_sig_collector #(.DATA_W(DATA_W), .SKIP(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .num_beats    (num_beats),
    .expected_sig (expected_sig),
    .resp_valid   (resp_valid),
    .resp_data    (resp_data),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .signature    (signature),
    .beat_count   (beat_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]       nb;
    logic [31:0]       exp_in;
    logic [DATA_W-1:0] data;
    logic [31:0]       exp_sig;
    logic              exp_pass;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [31:0] nb, input logic [31:0] exp_in);
    start        = 1'b1;
    num_beats    = nb;
    expected_sig = exp_in;
    tick();
    start        = 1'b0;
    num_beats    = 32'hDEAD_BEEF;
    expected_sig = 32'hCAFE_F00D;
  endtask

  task automatic beat(input logic valid, input logic [DATA_W-1:0] d);
    resp_valid = valid;
    resp_data  = d;
    tick();
    resp_valid = 1'b0;
  endtask

  function automatic logic [DATA_W-1:0] rand_beat();
    logic [DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < DATA_W; i++) r[i] = 1'($urandom_range(0, 1));
    return r;
  endfunction

  // Reference MISR step: bit-wise fold, then shift/feedback.
  function automatic logic [31:0] model_step(input logic [31:0] s, input logic [DATA_W-1:0] d);
    logic [31:0] f;
    f = '0;
    for (int i = 0; i < DATA_W; i++) f[i % 32] = f[i % 32] ^ d[i];
    return {s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0) ^ f;
  endfunction

  logic [31:0]       lcg_state;
  logic [DATA_W-1:0] lcg_beats[4];
  logic [DATA_W-1:0] stall_beats[3];
  logic [31:0]       model_sig;
  logic [DATA_W-1:0] one;

  function automatic logic [31:0] lcg_next(input logic [31:0] s);
    return s * 32'd1664525 + 32'd1013904223;
  endfunction

  initial begin
    rst_n = 1'b0; start = 1'b0; num_beats = '0; expected_sig = '0;
    resp_valid = 1'b0; resp_data = '0;
    one = '0; one[0] = 1'b1;

    vecs[0] = '{nb: 32'd1, exp_in: 32'hFB3E_E249, data: '0,                          exp_sig: 32'hFB3E_E249, exp_pass: 1'b1};
    vecs[1] = '{nb: 32'd1, exp_in: 32'h0,         data: (one << 32) | one,           exp_sig: 32'hFB3E_E249, exp_pass: 1'b0};
    vecs[2] = '{nb: 32'd1, exp_in: 32'hBB3E_E249, data: one << 158,                  exp_sig: 32'hBB3E_E249, exp_pass: 1'b1};
    vecs[3] = '{nb: 32'd1, exp_in: 32'h7B3E_E249, data: one << 31,                   exp_sig: 32'h7B3E_E249, exp_pass: 1'b1};
    vecs[4] = '{nb: 32'd2, exp_in: 32'hF2BC_D925, data: '0,                          exp_sig: 32'hF2BC_D925, exp_pass: 1'b1};
    vecs[5] = '{nb: 32'd0, exp_in: 32'hFFFF_FFFF, data: '0,                          exp_sig: 32'hFFFF_FFFF, exp_pass: 1'b1};
    vecs[6] = '{nb: 32'd0, exp_in: 32'h0,         data: '0,                          exp_sig: 32'hFFFF_FFFF, exp_pass: 1'b0};

    // Reset state, including start held during reset.
    start = 1'b1; num_beats = 32'd5;
    tick(); tick();
    start = 1'b0;
    check("rst_sig",  signature,  32'hFFFF_FFFF);
    check("rst_cnt",  beat_count, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_pass", {31'd0, pass}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Table-driven single-pattern runs; each re-arms from the previous DONE.
    for (int i = 0; i < 7; i++) begin
      start_run(vecs[i].nb, vecs[i].exp_in);
      if (vecs[i].nb != 0) begin
        check($sformatf("v%0d_busy", i), {31'd0, busy}, 32'd1);
        check($sformatf("v%0d_done0", i), {31'd0, done}, 32'd0);
        beat(1'b1, rand_beat());
        beat(1'b1, rand_beat());
        check($sformatf("v%0d_warm_sig", i), signature, 32'hFFFF_FFFF);
        check($sformatf("v%0d_warm_cnt", i), beat_count, 32'd0);
        for (int b = 0; b < int'(vecs[i].nb); b++) beat(1'b1, vecs[i].data);
      end
      check($sformatf("v%0d_sig", i),  signature, vecs[i].exp_sig);
      check($sformatf("v%0d_cnt", i),  beat_count, vecs[i].nb);
      check($sformatf("v%0d_done", i), {31'd0, done}, 32'd1);
      check($sformatf("v%0d_pass", i), {31'd0, pass}, {31'd0, vecs[i].exp_pass});
      check($sformatf("v%0d_busy_end", i), {31'd0, busy}, 32'd0);
    end

    // Stall handling, with a start pulse that must be ignored mid-run.
    for (int k = 0; k < 3; k++) stall_beats[k] = rand_beat();
    model_sig = 32'hFFFF_FFFF;
    for (int k = 0; k < 3; k++) model_sig = model_step(model_sig, stall_beats[k]);
    start_run(32'd3, model_sig);
    beat(1'b1, rand_beat());
    beat(1'b1, rand_beat());
    beat(1'b1, stall_beats[0]);
    check("stall_cnt1", beat_count, 32'd1);
    start = 1'b1; num_beats = 32'd0; expected_sig = 32'h0;
    beat(1'b0, rand_beat());
    start = 1'b0;
    check("stall_cnt2", beat_count, 32'd1);
    check("stall_busy", {31'd0, busy}, 32'd1);
    beat(1'b0, rand_beat());
    check("stall_done0", {31'd0, done}, 32'd0);
    beat(1'b1, stall_beats[1]);
    check("stall_cnt4", beat_count, 32'd2);
    beat(1'b0, rand_beat());
    check("stall_cnt5", beat_count, 32'd2);
    beat(1'b1, stall_beats[2]);
    check("stall_cnt6", beat_count, 32'd3);
    check("stall_done", {31'd0, done}, 32'd1);
    check("stall_pass", {31'd0, pass}, 32'd1);
    check("stall_sig",  signature, model_sig);
    beat(1'b1, rand_beat());
    check("done_hold_sig", signature, model_sig);
    check("done_hold_cnt", beat_count, 32'd3);

    // Re-arm from DONE with LCG-driven beats and a mismatching golden value.
    lcg_state = 32'd1791895503;
    for (int k = 0; k < 4; k++) begin
      for (int w = 0; w < 5; w++) begin
        lcg_state = lcg_next(lcg_state);
        if (w < 4) lcg_beats[k][w*32 +: 32] = lcg_state;
        else       lcg_beats[k][158:128]    = lcg_state[30:0];
      end
    end
    model_sig = 32'hFFFF_FFFF;
    for (int k = 0; k < 4; k++) model_sig = model_step(model_sig, lcg_beats[k]);
    for (int run = 0; run < 2; run++) begin
      start_run(32'd4, (run == 0) ? 32'h1234_5678 : model_sig);
      beat(1'b1, rand_beat());
      beat(1'b1, rand_beat());
      for (int k = 0; k < 4; k++) beat(1'b1, lcg_beats[k]);
      check($sformatf("lcg%0d_sig", run),  signature, model_sig);
      check($sformatf("lcg%0d_done", run), {31'd0, done}, 32'd1);
      check($sformatf("lcg%0d_pass", run), {31'd0, pass},
            {31'd0, (run == 0) ? (model_sig == 32'h1234_5678) : 1'b1});
    end

    // Reset mid-run after 5 collected beats of a 10-beat run.
    start_run(32'd10, 32'h0);
    beat(1'b1, rand_beat());
    beat(1'b1, rand_beat());
    for (int k = 0; k < 5; k++) beat(1'b1, rand_beat());
    check("mid_cnt_pre", beat_count, 32'd5);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_sig",  signature,  32'hFFFF_FFFF);
    check("mid_cnt",  beat_count, 32'd0);
    check("mid_busy", {31'd0, busy}, 32'd0);
    check("mid_done", {31'd0, done}, 32'd0);
    beat(1'b1, rand_beat());
    check("mid_idle_sig", signature, 32'hFFFF_FFFF);
    check("mid_idle_cnt", beat_count, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
